// File: rtl/cu_pkg.sv
// Shared control-unit definitions: sequencer state encoding and flag bit positions.
// Used by the sequencer, its watchdog and the handshake interface.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_BUS    = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam int FLAG_W     = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 0;

endpackage

// File: rtl/cu_sequencer_if.sv
// Sequencer <-> unit handshake bundle: chip-selects and PC out, ready/status back.
// master = sequencer side, slave = unit side.
interface cu_sequencer_if #(
    parameter int ADDR_W = 16
) ();
    import cu_pkg::*;

    logic              start;
    logic              ready_fcu;
    logic              ready_dec;
    logic              ready_eu;
    logic              ready_bus;
    logic              dec_need_bus;
    logic              dec_halt;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              cout;
    logic              c;
    logic              z;
    logic              cs_fcu;
    logic              cs_dec;
    logic              cs_eu;
    logic              cs_biu;
    logic [ADDR_W-1:0] fetch_address;
    logic [FLAG_W-1:0] flag;
    logic              busy;
    logic              halted;
    logic              fault;

    modport master (
        input  start, ready_fcu, ready_dec, ready_eu, ready_bus,
               dec_need_bus, dec_halt, br_taken, br_target, cout, c, z,
        output cs_fcu, cs_dec, cs_eu, cs_biu, fetch_address, flag, busy, halted, fault
    );

    modport slave (
        output start, ready_fcu, ready_dec, ready_eu, ready_bus,
               dec_need_bus, dec_halt, br_taken, br_target, cout, c, z,
        input  cs_fcu, cs_dec, cs_eu, cs_biu, fetch_address, flag, busy, halted, fault
    );

endinterface

// File: rtl/cu_watchdog.sv
// cu_watchdog: bounds each sequencer wait state; only built when CU_WATCHDOG_EN is defined.
// Latency: expire is combinational from the count and the current ready.
// Backpressure: none; counts cycles the awaited ready stays low, cleared on every state change.
module cu_watchdog
    import cu_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic wait_vld,
    input  logic rdy,
    output logic expire
);

    // Flag one count early so FAULT is entered on the edge where the count would hit all-ones.
    localparam logic [TMO_W-1:0] LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (wait_vld && !rdy) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expire = wait_vld && !rdy && (cnt_q == LAST);

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: fetch/decode/execute/bus control FSM driving unit chip-selects, PC and flags.
// Latency: one cycle minimum per phase (3 cycles per plain instruction, 4 with a bus phase).
// Backpressure: each phase waits on its unit's ready; CU_WATCHDOG_EN bounds waits and faults on timeout.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0,
    parameter int TMO_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    cu_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [FLAG_W-1:0] flag_q;
    logic              need_bus_q;
    logic              cs_fcu_q, cs_dec_q, cs_eu_q, cs_biu_q;
    logic              fetch_done, dec_done, exec_done, in_wait;

    assign fetch_done = (state_q == ST_FETCH)  && bus.ready_fcu;
    assign dec_done   = (state_q == ST_DECODE) && bus.ready_dec;
    assign exec_done  = (state_q == ST_EXEC)   && bus.ready_eu;
    assign in_wait    = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                        (state_q == ST_EXEC)  || (state_q == ST_BUS);

`ifdef CU_WATCHDOG_EN
    logic wait_rdy, wdt_expire;

    always_comb begin
        wait_rdy = 1'b0;
        case (state_q)
            ST_FETCH:  wait_rdy = bus.ready_fcu;
            ST_DECODE: wait_rdy = bus.ready_dec;
            ST_EXEC:   wait_rdy = bus.ready_eu;
            ST_BUS:    wait_rdy = bus.ready_bus;
            default:   wait_rdy = 1'b0;
        endcase
    end

    cu_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_d != state_q),
        .wait_vld (in_wait),
        .rdy      (wait_rdy),
        .expire   (wdt_expire)
    );
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_W != 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start)     state_d = ST_FETCH;
            ST_FETCH:  if (bus.ready_fcu) state_d = ST_DECODE;
            ST_DECODE: if (bus.ready_dec) state_d = bus.dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   if (bus.ready_eu)  state_d = need_bus_q ? ST_BUS : ST_FETCH;
            ST_BUS:    if (bus.ready_bus) state_d = ST_FETCH;
            default:                      state_d = state_q;
        endcase
`ifdef CU_WATCHDOG_EN
        if (wdt_expire) state_d = ST_FAULT;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            flag_q     <= '0;
            need_bus_q <= 1'b0;
            cs_fcu_q   <= 1'b0;
            cs_dec_q   <= 1'b0;
            cs_eu_q    <= 1'b0;
            cs_biu_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Chip-selects track the next state so each one drops right after its ready is taken.
            cs_fcu_q <= (state_d == ST_FETCH);
            cs_dec_q <= (state_d == ST_DECODE);
            cs_eu_q  <= (state_d == ST_EXEC);
            cs_biu_q <= (state_d == ST_BUS);
            if (dec_done) need_bus_q <= bus.dec_need_bus;
            if (exec_done && bus.br_taken) pc_q <= bus.br_target;
            else if (fetch_done)           pc_q <= pc_q + ADDR_W'(PC_STEP);
            if (exec_done) begin
                flag_q[FLAG_CARRY] <= bus.cout | bus.c;
                flag_q[FLAG_ZERO]  <= bus.z;
            end
        end
    end

    assign bus.cs_fcu        = cs_fcu_q;
    assign bus.cs_dec        = cs_dec_q;
    assign bus.cs_eu         = cs_eu_q;
    assign bus.cs_biu        = cs_biu_q;
    assign bus.fetch_address = pc_q;
    assign bus.flag          = flag_q;
    assign bus.busy          = in_wait;
    assign bus.halted        = (state_q == ST_HALT);
`ifdef CU_WATCHDOG_EN
    assign bus.fault         = (state_q == ST_FAULT);
`else
    assign bus.fault         = 1'b0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: table vectors, random instruction stream against an instruction-level model,
// and hand sequences for reset, halt, PC wrap and (with CU_WATCHDOG_EN) the watchdog.
module tb_cu_sequencer;

    logic clk, rst_a, rst_b;
    int   n_chk, n_fail, cyc;

    cu_sequencer_if #(.ADDR_W(16)) ia ();
    cu_sequencer_if #(.ADDR_W(4))  ib ();

    cu_sequencer #(.ADDR_W(16)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    cu_sequencer #(.ADDR_W(4), .TMO_W(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          df, dd, de, db;
        logic        nb, br;
        logic [15:0] tgt;
        logic        co, cc, zz;
        logic [15:0] exp_pc;
        logic [1:0]  exp_flag;
        int          exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic quiet_a();
        ia.start = 0; ia.ready_fcu = 0; ia.ready_dec = 0; ia.ready_eu = 0; ia.ready_bus = 0;
        ia.dec_need_bus = 0; ia.dec_halt = 0; ia.br_taken = 0; ia.br_target = '0;
        ia.cout = 0; ia.c = 0; ia.z = 0;
    endtask

    task automatic quiet_b();
        ib.start = 0; ib.ready_fcu = 0; ib.ready_dec = 0; ib.ready_eu = 0; ib.ready_bus = 0;
        ib.dec_need_bus = 0; ib.dec_halt = 0; ib.br_taken = 0; ib.br_target = '0;
        ib.cout = 0; ib.c = 0; ib.z = 0;
    endtask

    task automatic noise_a();
        ia.start = 1'($urandom); ia.ready_fcu = 1'($urandom); ia.ready_dec = 1'($urandom);
        ia.ready_eu = 1'($urandom); ia.ready_bus = 1'($urandom);
        ia.dec_need_bus = 1'($urandom); ia.dec_halt = 1'($urandom); ia.br_taken = 1'($urandom);
        ia.br_target = 16'($urandom); ia.cout = 1'($urandom); ia.c = 1'($urandom); ia.z = 1'($urandom);
    endtask

    task automatic restart_a();
        quiet_a();
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
    endtask

    // One phase of unit 'unit' (0 fetch, 1 decode, 2 exec, 3 bus); its ready rises after d wait cycles.
    task automatic run_phase(input int unit, input int d, input logic nb, input logic hl, input logic br,
                             input logic [15:0] tgt, input logic co, input logic cc, input logic zz);
        for (int k = 0; k <= d; k++) begin
            check("cs_onehot", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu}, 32'd8 >> unit);
            noise_a();
            case (unit)
                0: ia.ready_fcu = (k == d);
                1: ia.ready_dec = (k == d);
                2: ia.ready_eu  = (k == d);
                default: ia.ready_bus = (k == d);
            endcase
            if (k == d && unit == 1) begin
                ia.dec_need_bus = nb; ia.dec_halt = hl;
            end
            if (k == d && unit == 2) begin
                ia.br_taken = br; ia.br_target = tgt; ia.cout = co; ia.c = cc; ia.z = zz;
            end
            step();
        end
    endtask

    task automatic run_instr(input int df, input int dd, input int de, input int db,
                             input logic nb, input logic hl, input logic br, input logic [15:0] tgt,
                             input logic co, input logic cc, input logic zz);
        run_phase(0, df, nb, hl, br, tgt, co, cc, zz);
        run_phase(1, dd, nb, hl, br, tgt, co, cc, zz);
        if (!hl) begin
            run_phase(2, de, nb, hl, br, tgt, co, cc, zz);
            if (nb) run_phase(3, db, nb, hl, br, tgt, co, cc, zz);
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] exp_pc;
        logic [1:0]  exp_flag;
        int          t0, lat;
        int          df, dd, de, db;
        logic        nb, br, co, cc, zz;
        logic [15:0] tgt;

        n_chk = 0; n_fail = 0; cyc = 0;
        vecs[0] = '{0, 0, 0, 0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0001, 2'b10, 3};
        vecs[1] = '{0, 0, 0, 0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0040, 2'b11, 3};
        vecs[2] = '{0, 0, 0, 0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 2'b01, 4};
        vecs[3] = '{1, 2, 0, 3, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 2'b10, 10};
        vecs[4] = '{0, 0, 4, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b00, 7};
        vecs[5] = '{0, 0, 0, 4, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b00, 8};

        // Held in reset with start and every ready high: nothing may move.
        rst_a = 1'b0; rst_b = 1'b0;
        quiet_a(); quiet_b();
        ia.start = 1; ia.ready_fcu = 1; ia.ready_dec = 1; ia.ready_eu = 1; ia.ready_bus = 1;
        repeat (3) step();
        check("rst_cs", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu}, 0);
        check("rst_status", {ia.busy, ia.halted, ia.fault}, 0);
        check("rst_pc", ia.fetch_address, 0);
        check("rst_flag", ia.flag, 0);

        // Readies tied high: FETCH, DECODE, EXEC on consecutive cycles.
        rst_a = 1'b1;
        step();
        check("seq_fetch", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu, ia.fetch_address}, {4'b1000, 16'h0000});
        step();
        check("seq_decode", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu, ia.fetch_address}, {4'b0100, 16'h0001});
        step();
        check("seq_exec", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu, ia.busy}, {4'b0010, 1'b1});
        step();
        check("seq_refetch", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu, ia.fetch_address}, {4'b1000, 16'h0001});

        // Single-instruction vectors from reset.
        for (int i = 0; i < 6; i++) begin
            restart_a();
            t0 = cyc;
            run_instr(vecs[i].df, vecs[i].dd, vecs[i].de, vecs[i].db, vecs[i].nb, 1'b0, vecs[i].br,
                      vecs[i].tgt, vecs[i].co, vecs[i].cc, vecs[i].zz);
            check("vec_cs", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu}, 4'b1000);
            check("vec_pc", ia.fetch_address, vecs[i].exp_pc);
            check("vec_flag", ia.flag, vecs[i].exp_flag);
            check("vec_cycles", cyc - t0, vecs[i].exp_cyc);
        end

        // Random instruction stream against an instruction-level model.
        restart_a();
        exp_pc = 16'h0000;
        exp_flag = 2'b00;
        for (int i = 0; i < 40; i++) begin
            df = $urandom_range(0, 3); dd = $urandom_range(0, 3);
            de = $urandom_range(0, 3); db = $urandom_range(0, 3);
            nb = 1'($urandom); br = ($urandom_range(0, 2) == 0); tgt = 16'($urandom);
            co = 1'($urandom); cc = 1'($urandom); zz = 1'($urandom);
            t0 = cyc;
            run_instr(df, dd, de, db, nb, 1'b0, br, tgt, co, cc, zz);
            lat = (df + 1) + (dd + 1) + (de + 1) + (nb ? db + 1 : 0);
            exp_pc = br ? tgt : exp_pc + 16'd1;
            exp_flag = {co | cc, zz};
            check("rnd_pc", ia.fetch_address, exp_pc);
            check("rnd_flag", ia.flag, exp_flag);
            check("rnd_cycles", cyc - t0, lat);
        end

        // HALT is terminal: start and readies are ignored.
        run_instr(1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("halt_state", {ia.halted, ia.busy, ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu}, 6'b100000);
            noise_a();
            step();
        end
        check("halt_pc", ia.fetch_address, exp_pc + 16'd1);
        check("halt_flag", ia.flag, exp_flag);

        // Asynchronous reset while the EU is selected.
        restart_a();
        run_phase(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        run_phase(1, 0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        quiet_a();
        step(); step();
        check("mid_exec", {ia.cs_eu, ia.fetch_address}, {1'b1, 16'h0001});
        #1 rst_a = 1'b0;
        #1;
        check("arst_cs", {ia.cs_fcu, ia.cs_dec, ia.cs_eu, ia.cs_biu}, 0);
        check("arst_pc", ia.fetch_address, 0);
        check("arst_busy", ia.busy, 0);
        step();
        rst_a = 1'b1;
        step();
        check("arst_idle", {ia.busy, ia.cs_fcu}, 0);

        // 4-bit PC wraps from 15 to 0 on fetch completion.
        quiet_b();
        ib.ready_fcu = 1; ib.ready_dec = 1; ib.ready_eu = 1; ib.ready_bus = 1;
        ib.br_taken = 1; ib.br_target = 4'hF; ib.start = 1;
        rst_b = 1'b1;
        repeat (4) step();
        check("wrap_pre", {ib.cs_fcu, ib.fetch_address}, {1'b1, 4'hF});
        step();
        check("wrap_pc", {ib.cs_dec, ib.fetch_address}, {1'b1, 4'h0});

        // EXEC with ready_eu stuck low.
        rst_b = 1'b0;
        quiet_b();
        step();
        ib.ready_fcu = 1; ib.ready_dec = 1; ib.ready_bus = 1; ib.start = 1;
        rst_b = 1'b1;
        repeat (3) step();
        check("wdt_exec", ib.cs_eu, 1);
`ifdef CU_WATCHDOG_EN
        repeat (6) step();
        check("wdt_before", {ib.fault, ib.cs_eu}, 2'b01);
        step();
        check("wdt_fault", {ib.fault, ib.busy, ib.cs_fcu, ib.cs_dec, ib.cs_eu, ib.cs_biu}, 6'b100000);
        ib.ready_eu = 1;
        repeat (3) step();
        check("fault_terminal", {ib.fault, ib.cs_fcu}, 2'b10);
        rst_b = 1'b0;
        step();
        check("fault_rst", ib.fault, 0);
        ib.ready_eu = 0;
        rst_b = 1'b1;
        repeat (3) step();
        check("wdt_exec2", ib.cs_eu, 1);
        repeat (6) step();
        ib.ready_eu = 1;
        step();
        check("wdt_ready_wins", {ib.fault, ib.cs_fcu}, 2'b01);
`else
        repeat (20) step();
        check("no_wdt", {ib.fault, ib.cs_eu}, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 Parameter ADDR_W, 16, width of fetch address / program counter SHALL be parametrised.
REQ-002 Parameter PC_STEP, 1, increment applied to PC after each fetch SHALL be parametrised.
REQ-003 Parameter RESET_PC, 0, PC value on reset SHALL be parametrised.
REQ-004 Parameter TMO_W, 8, watchdog counter width SHALL be parametrised (used only when CU_WATCHDOG_EN defined).
REQ-005 Ports SHALL be:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 start  in  1  begin instruction sequencing from IDLE
 ready_fcu  in  1  fetch unit done
 ready_dec  in  1  decoder done
 ready_eu  in  1  execution unit done
 ready_bus  in  1  bus interface done
 dec_need_bus  in  1  decoded instruction requires a bus phase (sampled with ready_dec)
 dec_halt  in  1  decoded instruction is HALT (sampled with ready_dec)
 br_taken  in  1  branch taken (sampled with ready_eu)
 br_target  in  ADDR_W  branch destination
 cout, c, z  in  1 each  EU status (sampled with ready_eu)
 cs_fcu, cs_dec, cs_eu, cs_biu  out  1 each  unit chip-selects
 fetch_address  out  ADDR_W  current PC
 flag  out  2  {cout|c, z}, registered
 busy  out  1  high in any state except IDLE, HALT, FAULT
 halted  out  1  high in HALT
 fault  out  1  high in FAULT

Function
REQ-006 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, BUS, HALT, FAULT; registered, one transition per clock max.
REQ-007 IDLE -> FETCH when start=1; start SHALL be ignored in all other states.
REQ-008 FETCH -> DECODE on ready_fcu=1; DECODE -> HALT if dec_halt, else EXEC, on ready_dec=1.
REQ-009 EXEC -> BUS if latched need_bus=1, else FETCH, on ready_eu=1; BUS -> FETCH on ready_bus=1.
REQ-010 dec_need_bus SHALL be latched when ready_dec=1 and held until the next DECODE completion.
REQ-011 Chip-selects SHALL be registered outputs, exactly one high in FETCH/DECODE/EXEC/BUS, all low elsewhere; cs SHALL drop the cycle after its ready is sampled high.
REQ-012 A ready input asserted outside its own state SHALL be ignored.
REQ-013 PC SHALL advance by PC_STEP on FETCH completion, wrapping modulo 2^ADDR_W.
REQ-014 On EXEC completion with br_taken=1, PC SHALL load br_target, overriding any increment.
REQ-015 flag SHALL update only on EXEC completion: flag[1]=cout|c, flag[0]=z; otherwise hold.
REQ-016 Minimum latency per phase SHALL be 1 cycle; a full non-bus instruction with immediate readies SHALL take 3 cycles, a bus instruction 4.
REQ-017 HALT and FAULT SHALL be terminal until reset.

Reset
REQ-018 reset=0 SHALL asynchronously force state=IDLE, all cs=0, PC=RESET_PC, flag=0, busy=halted=fault=0, need_bus latch=0, watchdog=0, including mid-handshake.

Configuration
REQ-019 With CU_WATCHDOG_EN defined, a TMO_W-bit counter SHALL clear on entry to each wait state, increment each cycle the ready is low, and force FAULT when it reaches all-ones with ready still low.
REQ-020 Ready high in the cycle the counter reaches all-ones SHALL win (normal transition).
REQ-021 Without CU_WATCHDOG_EN, no counter SHALL exist, waits SHALL be unbounded, fault SHALL be tied 0.

Structure
REQ-022 State encoding and flag bit indices SHALL live in shared package cu_pkg.
REQ-023 Watchdog SHALL be a sub-module cu_watchdog, instantiated only under CU_WATCHDOG_EN.

Verification
REQ-024 reset low, start=1, all readies tied high -> cs_fcu, cs_dec, cs_eu high on consecutive cycles, fetch_address 0->1 after FETCH.
REQ-025 ADDR_W=4, PC=15, fetch completes -> fetch_address=0 (wrap).
REQ-026 EXEC completes with br_taken=1, br_target=0x0040, cout=0, c=1, z=1 -> fetch_address=0x0040, flag=2'b11.
REQ-027 dec_need_bus=1 at DECODE, ready_bus delayed 5 cycles -> cs_biu high 5 cycles, then FETCH; dec_halt=1 -> halted=1, all cs low forever.
REQ-028 CU_WATCHDOG_EN, TMO_W=3, ready_eu held low -> fault=1 after 7 wait cycles; ready_eu high on cycle 7 -> no fault.
REQ-029 reset pulsed low while cs_eu high -> cs_eu=0 asynchronously, state IDLE, PC=RESET_PC.
